// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU replacement.
// One FSM handles lookup, dirty-victim write-back and line refill over a valid/ready memory port.
module set_assoc_cache #(
   parameter int LINE_SIZE = 16,
   parameter int NUM_SETS  = 8,
   parameter int NUM_WAYS  = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   is_input_valid,
   input  logic [31:0]            addr,
   input  logic                   mem_read,
   input  logic                   mem_write,
   input  logic [31:0]            din,
   output logic                   is_ready,
   output logic                   is_output_valid,
   output logic [31:0]            dout,
   output logic                   is_hit,
   output logic                   mem_req_valid,
   output logic                   mem_req_write,
   output logic [31:0]            mem_addr,
   output logic [LINE_SIZE*8-1:0] mem_wdata,
   input  logic [LINE_SIZE*8-1:0] mem_rdata,
   input  logic                   mem_rdata_valid,
   input  logic                   mem_ready
);
   localparam int OFF_W  = $clog2(LINE_SIZE);
   localparam int IDX_W  = $clog2(NUM_SETS);
   localparam int TAG_W  = 32 - OFF_W - IDX_W;
   localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam int WSEL_W = (OFF_W > 2) ? OFF_W - 2 : 1;
   localparam int LINE_W = LINE_SIZE * 8;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COMPARE = 3'd1;
   localparam logic [2:0] S_WB_REQ  = 3'd2;
   localparam logic [2:0] S_WB_WAIT = 3'd3;
   localparam logic [2:0] S_RF_REQ  = 3'd4;
   localparam logic [2:0] S_RF_WAIT = 3'd5;

   logic [2:0]          state_reg;
   logic [31:0]         addr_reg;
   logic [31:0]         din_reg;
   logic                is_store_reg;
   logic                first_miss_reg;
   logic [WAY_W-1:0]    victim_reg;
   logic                mem_req_valid_reg;
   logic                mem_req_write_reg;
   logic [31:0]         mem_addr_reg;
   logic [LINE_W-1:0]   mem_wdata_reg;

   logic [NUM_SETS-1:0] valid_reg [NUM_WAYS];
   logic [NUM_SETS-1:0] dirty_reg [NUM_WAYS];
   logic [WAY_W-1:0]    age_reg   [NUM_WAYS][NUM_SETS];
   logic [TAG_W-1:0]    tag_mem   [NUM_WAYS][NUM_SETS];
   logic [LINE_W-1:0]   data_mem  [NUM_WAYS][NUM_SETS];

   logic [TAG_W-1:0]    tag;
   logic [IDX_W-1:0]    idx;
   logic [WSEL_W-1:0]   wsel;
   logic [NUM_WAYS-1:0] way_hit;
   logic                hit;
   logic [WAY_W-1:0]    hit_way;
   logic [WAY_W-1:0]    victim_way;
   logic [LINE_W-1:0]   hit_line;
   logic [LINE_W-1:0]   merged_line;
   logic [31:0]         hit_word;

   assign tag  = addr_reg[31 -: TAG_W];
   assign idx  = addr_reg[OFF_W +: IDX_W];
   assign wsel = WSEL_W'(addr_reg[OFF_W-1:0] >> 2);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_WAYS; gi++) begin : g_cmp
         assign way_hit[gi] = valid_reg[gi][idx] && (tag_mem[gi][idx] == tag);
      end
   endgenerate

   assign hit = |way_hit;

   always_comb begin
      hit_way = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--)
         if (way_hit[w]) hit_way = WAY_W'(w);
   end

   // Oldest way first, then overridden by the lowest-index invalid way if any.
   always_comb begin
      victim_way = '0;
      for (int w = 0; w < NUM_WAYS; w++)
         if (age_reg[w][idx] == WAY_W'(NUM_WAYS - 1)) victim_way = WAY_W'(w);
      for (int w = NUM_WAYS - 1; w >= 0; w--)
         if (!valid_reg[w][idx]) victim_way = WAY_W'(w);
   end

   always_comb begin
      hit_line    = data_mem[hit_way][idx];
      hit_word    = hit_line[32*wsel +: 32];
      merged_line = hit_line;
      merged_line[32*wsel +: 32] = din_reg;
   end

   assign is_ready        = (state_reg == S_IDLE);
   assign is_output_valid = (state_reg == S_COMPARE) && hit;
   assign is_hit          = is_output_valid && !first_miss_reg;
   assign dout            = (is_output_valid && !is_store_reg) ? hit_word : 32'd0;
   assign mem_req_valid   = mem_req_valid_reg;
   assign mem_req_write   = mem_req_write_reg;
   assign mem_addr        = mem_addr_reg;
   assign mem_wdata       = mem_wdata_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg         <= S_IDLE;
         addr_reg          <= '0;
         din_reg           <= '0;
         is_store_reg      <= 1'b0;
         first_miss_reg    <= 1'b0;
         victim_reg        <= '0;
         mem_req_valid_reg <= 1'b0;
         mem_req_write_reg <= 1'b0;
         mem_addr_reg      <= '0;
         mem_wdata_reg     <= '0;
         for (int w = 0; w < NUM_WAYS; w++) begin
            valid_reg[w] <= '0;
            dirty_reg[w] <= '0;
            for (int s = 0; s < NUM_SETS; s++) age_reg[w][s] <= WAY_W'(w);
         end
      end else begin
         mem_req_valid_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (is_input_valid && (mem_read ^ mem_write)) begin
                  addr_reg       <= addr;
                  din_reg        <= din;
                  is_store_reg   <= mem_write;
                  first_miss_reg <= 1'b0;
                  state_reg      <= S_COMPARE;
               end
            end
            S_COMPARE: begin
               if (hit) begin
                  if (is_store_reg) dirty_reg[hit_way][idx] <= 1'b1;
                  for (int w = 0; w < NUM_WAYS; w++) begin
                     if (WAY_W'(w) == hit_way)
                        age_reg[w][idx] <= '0;
                     else if (age_reg[w][idx] < age_reg[hit_way][idx])
                        age_reg[w][idx] <= age_reg[w][idx] + WAY_W'(1);
                  end
                  state_reg <= S_IDLE;
               end else begin
                  first_miss_reg <= 1'b1;
                  victim_reg     <= victim_way;
                  state_reg      <= (valid_reg[victim_way][idx] && dirty_reg[victim_way][idx])
                                    ? S_WB_REQ : S_RF_REQ;
               end
            end
            S_WB_REQ: begin
               if (mem_ready) begin
                  mem_req_valid_reg <= 1'b1;
                  mem_req_write_reg <= 1'b1;
                  mem_addr_reg      <= {tag_mem[victim_reg][idx], idx, {OFF_W{1'b0}}};
                  mem_wdata_reg     <= data_mem[victim_reg][idx];
                  state_reg         <= S_WB_WAIT;
               end
            end
            S_WB_WAIT: begin
               // Memory only drops ready after seeing the strobe, so skip the strobe cycle itself.
               if (!mem_req_valid_reg && mem_ready) begin
                  dirty_reg[victim_reg][idx] <= 1'b0;
                  state_reg                  <= S_RF_REQ;
               end
            end
            S_RF_REQ: begin
               if (mem_ready) begin
                  mem_req_valid_reg <= 1'b1;
                  mem_req_write_reg <= 1'b0;
                  mem_addr_reg      <= {tag, idx, {OFF_W{1'b0}}};
                  state_reg         <= S_RF_WAIT;
               end
            end
            S_RF_WAIT: begin
               if (mem_rdata_valid) begin
                  valid_reg[victim_reg][idx] <= 1'b1;
                  dirty_reg[victim_reg][idx] <= 1'b0;
                  state_reg                  <= S_COMPARE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Tag and line storage carry no reset; valid bits guard them.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_reg == S_RF_WAIT && mem_rdata_valid) begin
            data_mem[victim_reg][idx] <= mem_rdata;
            tag_mem[victim_reg][idx]  <= tag;
         end else if (state_reg == S_COMPARE && hit && is_store_reg) begin
            data_mem[hit_way][idx] <= merged_line;
         end
      end
   end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: vector table for loads/stores plus hand-written
// sequences for dropped requests, memory stall and reset during refill.
module tb_set_assoc_cache;
   localparam int LW = 128;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          is_input_valid = 1'b0;
   logic [31:0]   addr = '0;
   logic          mem_read = 1'b0;
   logic          mem_write = 1'b0;
   logic [31:0]   din = '0;
   logic          is_ready, is_output_valid, is_hit;
   logic [31:0]   dout;
   logic          mem_req_valid, mem_req_write;
   logic [31:0]   mem_addr;
   logic [LW-1:0] mem_wdata;
   logic [LW-1:0] mem_rdata = '0;
   logic          mem_rdata_valid = 1'b0;
   logic          mem_ready = 1'b0;

   set_assoc_cache #(.LINE_SIZE(16), .NUM_SETS(8), .NUM_WAYS(2)) dut (
      .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
      .mem_read(mem_read), .mem_write(mem_write), .din(din), .is_ready(is_ready),
      .is_output_valid(is_output_valid), .dout(dout), .is_hit(is_hit),
      .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
      .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   // Memory model: 3-cycle latency, drops ready while busy, logs every request.
   logic [LW-1:0] mem_lines [256];
   logic          log_wr   [64];
   logic [31:0]   log_addr [64];
   logic [31:0]   log_w0   [64];
   int            req_cnt = 0;
   int            viol = 0;
   bit            stall = 1'b0;
   bit            hold = 1'b0;
   bit            busy = 1'b0;
   int            cnt = 0;
   logic          pend_wr = 1'b0;
   logic [31:0]   pend_addr = '0;
   logic [LW-1:0] pend_data = '0;

   always @(posedge clk) begin
      bit nb;
      nb = busy;
      mem_rdata_valid <= 1'b0;
      if (mem_req_valid) begin
         if (!mem_ready) viol <= viol + 1;
         if (req_cnt < 64) begin
            log_wr[req_cnt]   <= mem_req_write;
            log_addr[req_cnt] <= mem_addr;
            log_w0[req_cnt]   <= mem_wdata[31:0];
         end
         req_cnt   <= req_cnt + 1;
         pend_wr   <= mem_req_write;
         pend_addr <= mem_addr;
         pend_data <= mem_wdata;
         cnt       <= 3;
         nb = 1'b1;
      end else if (busy) begin
         if (cnt > 0) cnt <= cnt - 1;
         else if (pend_wr) begin
            mem_lines[pend_addr[11:4]] <= pend_data;
            nb = 1'b0;
         end else if (!hold) begin
            mem_rdata       <= mem_lines[pend_addr[11:4]];
            mem_rdata_valid <= 1'b1;
            nb = 1'b0;
         end
      end
      busy      <= nb;
      mem_ready <= !stall && !nb;
   end

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset(input bit chk);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      if (chk) begin
         check("reset_flags",
               32'({is_ready, is_output_valid, is_hit, mem_req_valid, mem_req_write}),
               32'b10000);
         check("reset_dout", dout, 32'd0);
         check("reset_mem_addr", mem_addr, 32'd0);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_txn(input bit st, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic h, output int cyc,
                          output int nreq);
      int start;
      @(negedge clk);
      is_input_valid = 1'b1;
      mem_read = !st;
      mem_write = st;
      addr = a;
      din = d;
      start = req_cnt;
      @(posedge clk);
      #1;
      is_input_valid = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      cyc = 1;
      while (!is_output_valid && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!is_output_valid) begin
         total++;
         bad++;
         $display("FAIL txn_timeout: addr %h got no is_output_valid in %0d cycles", a, cyc);
      end
      rd = dout;
      h = is_hit;
      nreq = req_cnt - start;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        rst;
      logic        st;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] dout;
      logic        hit;
      int          nreq;
      logic [31:0] a0;
      logic        wr0;
      logic [31:0] w0;
      logic [31:0] a1;
   } vec_t;

   vec_t tbl[19];

   initial begin
      logic [31:0] rd;
      logic        h;
      int          cyc, nreq, start;

      for (int l = 0; l < 256; l++)
         for (int w = 0; w < 4; w++)
            mem_lines[l][32*w +: 32] = (32'(l) << 8) | (32'hC0 + 32'(w));
      mem_lines[16] = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

      //          rst   st    addr        din           dout          hit  nreq a0          wr0   w0      a1
      tbl[0]  = '{1'b1, 1'b0, 32'h100, 32'h0,        32'hA0,       1'b0, 1, 32'h100, 1'b0, 32'h0,  32'h0};
      tbl[1]  = '{1'b0, 1'b0, 32'h104, 32'h0,        32'hA1,       1'b1, 0, 32'h0,   1'b0, 32'h0,  32'h0};
      tbl[2]  = '{1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 32'h0,        1'b1, 0, 32'h0,   1'b0, 32'h0,  32'h0};
      tbl[3]  = '{1'b0, 1'b0, 32'h104, 32'h0,        32'hDEADBEEF, 1'b1, 0, 32'h0,   1'b0, 32'h0,  32'h0};
      tbl[4]  = '{1'b0, 1'b0, 32'h10C, 32'h0,        32'hA3,       1'b1, 0, 32'h0,   1'b0, 32'h0,  32'h0};
      tbl[5]  = '{1'b1, 1'b0, 32'h000, 32'h0,        32'hC0,       1'b0, 1, 32'h000, 1'b0, 32'h0,  32'h0};
      tbl[6]  = '{1'b0, 1'b0, 32'h080, 32'h0,        32'h8C0,      1'b0, 1, 32'h080, 1'b0, 32'h0,  32'h0};
      tbl[7]  = '{1'b0, 1'b0, 32'h000, 32'h0,        32'hC0,       1'b1, 0, 32'h0,   1'b0, 32'h0,  32'h0};
      tbl[8]  = '{1'b0, 1'b0, 32'h100, 32'h0,        32'hA0,       1'b0, 1, 32'h100, 1'b0, 32'h0,  32'h0};
      tbl[9]  = '{1'b0, 1'b0, 32'h000, 32'h0,        32'hC0,       1'b1, 0, 32'h0,   1'b0, 32'h0,  32'h0};
      tbl[10] = '{1'b0, 1'b0, 32'h080, 32'h0,        32'h8C0,      1'b0, 1, 32'h080, 1'b0, 32'h0,  32'h0};
      tbl[11] = '{1'b1, 1'b1, 32'h000, 32'h11,       32'h0,        1'b0, 1, 32'h000, 1'b0, 32'h0,  32'h0};
      tbl[12] = '{1'b0, 1'b1, 32'h080, 32'h22,       32'h0,        1'b0, 1, 32'h080, 1'b0, 32'h0,  32'h0};
      tbl[13] = '{1'b0, 1'b0, 32'h100, 32'h0,        32'hA0,       1'b0, 2, 32'h000, 1'b1, 32'h11, 32'h100};
      tbl[14] = '{1'b0, 1'b0, 32'h000, 32'h0,        32'h11,       1'b0, 2, 32'h080, 1'b1, 32'h22, 32'h000};
      tbl[15] = '{1'b0, 1'b0, 32'h084, 32'h0,        32'h8C1,      1'b0, 1, 32'h080, 1'b0, 32'h0,  32'h0};
      tbl[16] = '{1'b0, 1'b1, 32'h234, 32'h55,       32'h0,        1'b0, 1, 32'h230, 1'b0, 32'h0,  32'h0};
      tbl[17] = '{1'b0, 1'b0, 32'h234, 32'h0,        32'h55,       1'b1, 0, 32'h0,   1'b0, 32'h0,  32'h0};
      tbl[18] = '{1'b0, 1'b0, 32'h230, 32'h0,        32'h23C0,     1'b1, 0, 32'h0,   1'b0, 32'h0,  32'h0};

      for (int i = 0; i < 19; i++) begin
         if (tbl[i].rst) do_reset(i == 0);
         start = req_cnt;
         run_txn(tbl[i].st, tbl[i].a, tbl[i].d, rd, h, cyc, nreq);
         $display("txn %0d: %s addr=%h din=%h dout=%h hit=%0d cycles=%0d memreqs=%0d",
                  i, tbl[i].st ? "st" : "ld", tbl[i].a, tbl[i].d, rd, h, cyc, nreq);
         if (!tbl[i].st) check($sformatf("v%0d_dout", i), rd, tbl[i].dout);
         check($sformatf("v%0d_hit", i), 32'(h), 32'(tbl[i].hit));
         check($sformatf("v%0d_nreq", i), 32'(nreq), 32'(tbl[i].nreq));
         if (tbl[i].hit) check($sformatf("v%0d_latency", i), 32'(cyc), 32'd1);
         if (tbl[i].nreq >= 1 && nreq >= 1) begin
            check($sformatf("v%0d_req0_addr", i), log_addr[start], tbl[i].a0);
            check($sformatf("v%0d_req0_wr", i), 32'(log_wr[start]), 32'(tbl[i].wr0));
            if (tbl[i].wr0) check($sformatf("v%0d_wb_word0", i), log_w0[start], tbl[i].w0);
         end
         if (tbl[i].nreq == 2 && nreq == 2) begin
            check($sformatf("v%0d_req1_addr", i), log_addr[start + 1], tbl[i].a1);
            check($sformatf("v%0d_req1_wr", i), 32'(log_wr[start + 1]), 32'd0);
         end
         check($sformatf("v%0d_ready_after", i), 32'(is_ready), 32'd1);
      end

      // Requests with both or neither op set are dropped.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         is_input_valid = 1'b1;
         mem_read = (k == 0);
         mem_write = (k == 0);
         addr = 32'h300;
         @(posedge clk);
         #1;
         is_input_valid = 1'b0;
         mem_read = 1'b0;
         mem_write = 1'b0;
         check($sformatf("drop%0d_state", k), 32'({is_ready, is_output_valid}), 32'b10);
         $display("txn drop%0d: rd=wr=%0d ready=%0d out_valid=%0d", k, k == 0, is_ready,
                  is_output_valid);
      end

      // Memory stall: no strobe while mem_ready is low, strobe the cycle after it rises.
      do_reset(1'b0);
      stall = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      is_input_valid = 1'b1;
      mem_read = 1'b1;
      addr = 32'h200;
      @(posedge clk);
      #1;
      is_input_valid = 1'b0;
      mem_read = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("stall_c%0d", k), 32'({mem_req_valid, is_ready}), 32'b00);
      end
      stall = 1'b0;
      @(posedge clk);
      #1;
      check("stall_no_early_req", 32'(mem_req_valid), 32'd0);
      @(posedge clk);
      #1;
      check("stall_req_issued", 32'(mem_req_valid), 32'd1);
      check("stall_req_addr", mem_addr, 32'h200);
      cyc = 0;
      while (!is_output_valid && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("stall_dout", dout, 32'h20C0);
      check("stall_hit", 32'(is_hit), 32'd0);
      $display("txn stall: ld addr=00000200 dout=%h hit=%0d", dout, is_hit);
      @(posedge clk);
      #1;

      // Reset while waiting for refill data; the late response must be ignored.
      hold = 1'b1;
      start = req_cnt;
      @(negedge clk);
      is_input_valid = 1'b1;
      mem_read = 1'b1;
      addr = 32'h300;
      @(posedge clk);
      #1;
      is_input_valid = 1'b0;
      mem_read = 1'b0;
      cyc = 0;
      while (req_cnt == start && cyc < 50) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("rst_mid_req_seen", 32'(req_cnt - start), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_state", 32'({is_ready, mem_req_valid}), 32'b10);
      @(negedge clk);
      reset = 1'b0;
      hold = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("rst_mid_idle", 32'({is_ready, is_output_valid}), 32'b10);
      run_txn(1'b0, 32'h300, 32'h0, rd, h, cyc, nreq);
      $display("txn rst_mid: ld addr=00000300 dout=%h hit=%0d memreqs=%0d", rd, h, nreq);
      check("rst_mid_reload_hit", 32'(h), 32'd0);
      check("rst_mid_reload_dout", rd, 32'h30C0);
      check("rst_mid_reload_nreq", 32'(nreq), 32'd1);

      check("ready_protocol", 32'(viol), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
